conv_encoder_punct: RTL

Transmit-side convolutional encoder with puncturing for the 802.11a PHY. It is the counterpart of the hard-decision Viterbi decoder in the receive chain. Each accepted data bit is encoded with the K=7 code (generators g0=133 octal, g1=171 octal). The resulting A/B pair is punctured to rate 1/2, 2/3 or 3/4, and the kept coded bits are emitted one per cycle over a valid/ready stream. The block sits between the scrambler and the interleaver.

---
 rtl/conv_encoder_punct.sv | 117 +++++++++++
 1 files changed

// File: rtl/conv_encoder_punct.sv
// K=7 convolutional encoder (g0=133, g1=171 octal) with 802.11a puncturing
// to rate 1/2, 2/3 or 3/4; coded bits leave one per cycle on a valid/ready stream.
module conv_encoder_punct (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] rate,
   input  logic       in_valid,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output logic       out_bit,
   output logic       out_last,
   input  logic       out_ready
);

   localparam int unsigned SR_W   = 6;
   localparam int unsigned PH_W   = 2;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned RATE_W = 2;

   localparam logic [RATE_W-1:0] RATE_2_3 = RATE_W'(1);
   localparam logic [RATE_W-1:0] RATE_3_4 = RATE_W'(2);

   logic [SR_W-1:0]   sr;
   logic [PH_W-1:0]   ph;
   logic [RATE_W-1:0] rate_q;
   logic [CNT_W-1:0]  cnt;
   logic              sec_bit;
   logic              sec_last;

   logic xfer_c;
   logic accept_c;
   logic code_a_c;
   logic code_b_c;
   logic keep_a_c;
   logic keep_b_c;
   logic ph_wrap_c;

   // Lookahead lets a new bit load in the same edge the final pending bit leaves.
   assign xfer_c   = out_valid && out_ready;
   assign in_ready = !rst && !start &&
                     ((cnt == CNT_W'(0)) || ((cnt == CNT_W'(1)) && xfer_c));
   assign accept_c = in_valid && in_ready;

   // sr[0] is d1 ... sr[5] is d6
   assign code_a_c = in_bit ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
   assign code_b_c = in_bit ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];

   // Puncture pattern and period for the latched rate; reserved code acts as 1/2.
   always_comb begin
      keep_a_c  = 1'b1;
      keep_b_c  = 1'b1;
      ph_wrap_c = 1'b1;
      case (rate_q)
         RATE_2_3: begin
            keep_b_c  = (ph == PH_W'(0));
            ph_wrap_c = (ph == PH_W'(1));
         end
         RATE_3_4: begin
            keep_a_c  = (ph != PH_W'(2));
            keep_b_c  = (ph != PH_W'(1));
            ph_wrap_c = (ph == PH_W'(2));
         end
         default: ;
      endcase
   end

   // Output register is the head of a two-entry pending buffer; sec_* is the second entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         ph        <= '0;
         rate_q    <= '0;
         cnt       <= '0;
         sec_bit   <= 1'b0;
         sec_last  <= 1'b0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_last  <= 1'b0;
      end else if (start) begin
         sr        <= '0;
         ph        <= '0;
         rate_q    <= rate;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept_c) begin
         sr        <= {sr[SR_W-2:0], in_bit};
         ph        <= ph_wrap_c ? PH_W'(0) : PH_W'(ph + PH_W'(1));
         out_valid <= 1'b1;
         if (keep_a_c && keep_b_c) begin
            out_bit  <= code_a_c;
            out_last <= 1'b0;
            sec_bit  <= code_b_c;
            sec_last <= in_last;
            cnt      <= CNT_W'(2);
         end else begin
            out_bit  <= keep_a_c ? code_a_c : code_b_c;
            out_last <= in_last;
            cnt      <= CNT_W'(1);
         end
      end else if (xfer_c) begin
         if (cnt == CNT_W'(2)) begin
            out_bit  <= sec_bit;
            out_last <= sec_last;
            cnt      <= CNT_W'(1);
         end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= '0;
         end
      end
   end

endmodule
